// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
//
// Shared definitions for the branch direction predictor:
//   - idx_mode_e     : table indexing mode (bimodal or gshare)
//   - idx_width()    : index width for a given number of counters
//   - ctr_msb()      : bit position of the counter direction bit
//   - ctr_reset_val(): weakly-not-taken counter reset value
//   - STAT_MAX       : saturation value of the optional statistics counters
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN is undefined by default.
// Define it on the tool command line to enable the statistics ports.
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    // Widest counter the table supports; reset values are computed at this
    // width and narrowed by the user.
    localparam int CTR_WIDTH_MAX = 4;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        IDX_BIMODAL = 1'b0,
        IDX_GSHARE  = 1'b1
    } idx_mode_e;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int ctr_msb(input int ctr_width);
        return ctr_width - 1;
    endfunction

    // 2^(w-1)-1: the largest value whose MSB is clear, i.e. weakly not-taken.
    function automatic logic [CTR_WIDTH_MAX-1:0] ctr_reset_val(input int ctr_width);
        return CTR_WIDTH_MAX'((1 << (ctr_width - 1)) - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr_table.sv
// ---------------------------------------------------------------------------
// sat_ctr_table
//
// Array of ENTRIES saturating up/down counters, CTR_WIDTH bits each.
// One asynchronous read port and one synchronous read-modify-write port.
// A read of the entry being written in the same cycle returns the old value.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset; all counters -> weakly not-taken
//   rd_idx  in   read index
//   rd_ctr  out  counter value at rd_idx (combinational)
//   wr_en   in   apply an increment/decrement at the clock edge
//   wr_idx  in   write index
//   wr_inc  in   1 = increment (saturate at all-ones), 0 = decrement (saturate at 0)
// ---------------------------------------------------------------------------
module sat_ctr_table
    import branch_predictor_pkg::*;
#(
    parameter  int ENTRIES   = 64,
    parameter  int CTR_WIDTH = 2,
    localparam int IDX_W     = idx_width(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [CTR_WIDTH-1:0] rd_ctr,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 wr_inc
);

    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_reset_val(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

    logic [CTR_WIDTH-1:0] ctr [ENTRIES];

    function automatic logic [CTR_WIDTH-1:0] sat_step(
        input logic [CTR_WIDTH-1:0] val,
        input logic                 inc
    );
        if (inc) begin
            return (val == CTR_MAX) ? val : val + 1'b1;
        end
        return (val == '0) ? val : val - 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= sat_step(ctr[wr_idx], wr_inc);
        end
    end

    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direction predictor for conditional branches. ID looks up lk_pc and gets a
// zero-latency prediction; EX trains the counter table with the resolved
// outcome. Indexing is bimodal (PC bits) or gshare (PC bits XOR global
// history). The global history register (GHR) is updated speculatively on
// each enabled lookup and repaired from the snapshot carried by a
// mispredicted branch.
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN (undefined by default).
// When defined, three saturating 32-bit statistics outputs are added.
//
// Parameters:
//   ENTRIES    number of counters (power of two, >= 4)
//   CTR_WIDTH  counter width, 1..4
//   GSHARE     0 = bimodal index, 1 = index XOR GHR
//   HIST_WIDTH GHR width, 1..log2(ENTRIES)
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bp_enable      0 = predict not-taken and freeze speculative GHR updates
//   lk_valid       conditional branch in ID (not stalled/flushed)
//   lk_pc          PC of the ID instruction
//   lk_taken       predicted direction (driven regardless of lk_valid)
//   lk_ghr         GHR before this lookup, carried down the pipe
//   up_valid       conditional branch resolved in EX
//   up_pc          PC of the resolved branch
//   up_ghr         GHR snapshot that travelled with the branch
//   up_taken       actual outcome
//   up_mispred     prediction was wrong; GHR is repaired
//   stat_lookups   (STATS_EN) enabled lookups
//   stat_updates   (STATS_EN) training updates
//   stat_mispreds  (STATS_EN) mispredicted branches
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int CTR_WIDTH  = 2,
    parameter int GSHARE     = 0,
    parameter int HIST_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bp_enable,
    input  logic                  lk_valid,
    input  logic [31:0]           lk_pc,
    output logic                  lk_taken,
    output logic [HIST_WIDTH-1:0] lk_ghr,
    input  logic                  up_valid,
    input  logic [31:0]           up_pc,
    input  logic [HIST_WIDTH-1:0] up_ghr,
    input  logic                  up_taken,
    input  logic                  up_mispred
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_updates,
    output logic [31:0]           stat_mispreds
`endif
);

    localparam int        IDX_W    = idx_width(ENTRIES);
    localparam int        CTR_MSB  = ctr_msb(CTR_WIDTH);
    localparam idx_mode_e IDX_MODE = (GSHARE != 0) ? IDX_GSHARE : IDX_BIMODAL;

    logic [HIST_WIDTH-1:0] ghr;
    logic [HIST_WIDTH-1:0] ghr_spec;
    logic [HIST_WIDTH-1:0] ghr_repair;
    logic [IDX_W-1:0]      lk_hash;
    logic [IDX_W-1:0]      up_hash;
    logic [IDX_W-1:0]      lk_idx;
    logic [IDX_W-1:0]      up_idx;
    logic [CTR_WIDTH-1:0]  lk_ctr;

    // Index hashing. Word-aligned PC bits select the counter; in gshare mode
    // the zero-extended history is folded in. Each side uses its own history:
    // the live GHR for lookups, the carried snapshot for training, so a branch
    // trains the same entry it was predicted from.
    assign lk_hash = (IDX_MODE == IDX_GSHARE) ? IDX_W'(ghr)    : '0;
    assign up_hash = (IDX_MODE == IDX_GSHARE) ? IDX_W'(up_ghr) : '0;
    assign lk_idx  = lk_pc[IDX_W+1:2] ^ lk_hash;
    assign up_idx  = up_pc[IDX_W+1:2] ^ up_hash;

    sat_ctr_table #(
        .ENTRIES   (ENTRIES),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (lk_idx),
        .rd_ctr (lk_ctr),
        .wr_en  (up_valid),
        .wr_idx (up_idx),
        .wr_inc (up_taken)
    );

    // Lookup reads pre-update state: no bypass from a same-cycle update.
    assign lk_taken = bp_enable & lk_ctr[CTR_MSB];
    assign lk_ghr   = ghr;

    // Next-history candidates. A one-bit history is simply the inserted bit.
    generate
        if (HIST_WIDTH == 1) begin : g_hist_one
            assign ghr_spec   = lk_taken;
            assign ghr_repair = up_taken;
        end else begin : g_hist_multi
            assign ghr_spec   = {ghr[HIST_WIDTH-2:0], lk_taken};
            assign ghr_repair = {up_ghr[HIST_WIDTH-2:0], up_taken};
        end
    endgenerate

    // Repair has priority: a lookup in the same cycle as a mispredict is on
    // the wrong path and must not be folded into history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (up_valid && up_mispred) begin
            ghr <= ghr_repair;
        end else if (lk_valid && bp_enable) begin
            ghr <= ghr_spec;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == STAT_MAX) ? val : val + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups  <= '0;
            stat_updates  <= '0;
            stat_mispreds <= '0;
        end else begin
            if (lk_valid && bp_enable) begin
                stat_lookups <= sat_inc32(stat_lookups);
            end
            if (up_valid) begin
                stat_updates <= sat_inc32(stat_updates);
            end
            if (up_valid && up_mispred) begin
                stat_mispreds <= sat_inc32(stat_mispreds);
            end
        end
    end
`endif

    // PC bits outside the index field, the counter bits below the direction
    // bit and (depending on configuration) parts of up_ghr are intentionally
    // not used.
    logic unused_bits;
    assign unused_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0],
                           up_pc[31:IDX_W+2], up_pc[1:0],
                           up_ghr, lk_ctr};

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direction predictor for conditional branches in the 5-stage RV32 core.
- Replaces a static not-taken policy. ID looks up `id_pc`; EX trains the table with the resolved outcome.
- Table of saturating counters, with a selectable bimodal or gshare indexing mode and a speculative global history register (GHR).
- Misprediction repair: EX returns the GHR snapshot that travelled down the pipe with the branch.

Parameters:
- ENTRIES, 64, number of counters; power of two, at least 4; IDX_W = clog2(ENTRIES).
- CTR_WIDTH, 2, counter width in bits, 1..4.
- GSHARE, 0, 0 = bimodal index, 1 = index XORed with the GHR.
- HIST_WIDTH, 6, GHR width, 1..IDX_W; the GHR is present but ignored for indexing when GSHARE=0.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- bp_enable  in  1  0 = predict not-taken and freeze the GHR; training continues
- lk_valid  in  1  conditional branch in ID, not stalled or flushed
- lk_pc  in  32  PC of the ID instruction
- lk_taken  out  1  predicted direction
- lk_ghr  out  HIST_WIDTH  GHR value before this lookup; pipelined with the branch
- up_valid  in  1  conditional branch resolved in EX
- up_pc  in  32  PC of the resolved branch
- up_ghr  in  HIST_WIDTH  lk_ghr that travelled with the branch
- up_taken  in  1  actual outcome
- up_mispred  in  1  prediction was wrong; EX flushes younger instructions this cycle

Behaviour:
- Single clock domain. All state is cleared asynchronously on rst, with no synchronous reset path.
- Reset values:
  - Every counter = 2^(CTR_WIDTH-1)-1 (weakly not-taken).
  - GHR = 0.
  - lk_taken = 0.
  - Stats counters = 0.
- Index:
  - lk_idx = lk_pc[IDX_W+1:2] XOR (GSHARE ? zero-extended GHR : 0).
  - up_idx = up_pc[IDX_W+1:2] XOR (GSHARE ? zero-extended up_ghr : 0).
- Lookup is combinational from registered state, with zero-cycle latency.
  - lk_taken = bp_enable & ctr[lk_idx][MSB].
  - lk_taken is driven regardless of lk_valid.
- Training happens at the clock edge when up_valid = 1:
  - If up_taken, ctr[up_idx] increments, saturating at all-ones.
  - Otherwise it decrements, saturating at zero.
  - up_mispred does not affect training.
- GHR update, in priority order:
  1. up_valid & up_mispred: GHR <= {up_ghr[HIST_WIDTH-2:0], up_taken}. This repairs wrong-path speculation and overrides a same-cycle lookup, which is on the wrong path.
  2. lk_valid & bp_enable: GHR <= {GHR[HIST_WIDTH-2:0], lk_taken}.
  3. Otherwise hold.
  - When HIST_WIDTH = 1, the shift reduces to GHR <= the inserted bit.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update counter. There is no bypass.
- up_mispred with up_valid = 0 is ignored.
- A reset asserted mid-stream discards all history. The first lookup after release predicts not-taken.
- bp_enable deassertion:
  - Takes effect combinationally on lk_taken.
  - The GHR holds while bp_enable = 0, except for mispredict repair, which still applies.
- PC bits [1:0] and bits above IDX_W+1 do not contribute to the index. Aliasing is permitted.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined: adds 32-bit output ports stat_lookups, stat_updates and stat_mispreds.
  - They increment on, respectively, lk_valid & bp_enable, up_valid, and up_valid & up_mispred.
  - They saturate at 32'hFFFF_FFFF and clear on rst.
  - The core maps them to read-only CSR/MMIO.
- Undefined: these ports and registers do not exist, and the predictor behaviour is identical.

Decomposition:
- Shared header bp_defs.vh holds:
  - The counter reset value function.
  - Localparams for IDX_W and the counter MSB.
  - The BRANCH_PREDICTOR_STATS_EN default (undefined).
- Sub-module sat_ctr_table (ENTRIES, CTR_WIDTH):
  - One asynchronous read port and one synchronous saturating inc/dec write port.
  - Asynchronous reset.
- The top level holds index hashing, the GHR and stats.

Test Plan:
1. Reset, then lookup of lk_pc = 0x4000_0010 with bp_enable = 1 -> lk_taken = 0 and lk_ghr = 0.
2. Bimodal, CTR_WIDTH = 2: three updates of up_pc = 0x4000_0010 taken, then three not-taken -> lk_taken reads 1, 1, 1, then 1, 0, 0. Counter values go 1→2→3→3→2→1→0 (saturates at 3).
3. Gshare, HIST_WIDTH = 4: lookups with predictions 1, 0, 1 -> GHR = 4'b0101. A mispredict update with up_ghr = 4'b0010 and up_taken = 1, in the same cycle as lk_valid -> GHR = 4'b0101 (repair wins over the lookup).
4. Same-cycle lookup and taken update of the same index, with the counter at 1 -> lk_taken = 0 that cycle and 1 the next.
5. bp_enable = 0 with counter = 3 -> lk_taken = 0 and the GHR is unchanged. An update still trains: after re-enable, lk_taken = 1.
6. With BRANCH_PREDICTOR_STATS_EN defined: 10 lookups, 4 updates, 1 mispredict, then rst mid-run -> counters read 10/4/1 before rst and 0/0/0 after.
